// File: rtl/sprite_pkg.sv
// sprite_fetch shared types and constants.
// Register map, sprite geometry, colour helpers and the position bundle.
package sprite_pkg;

  localparam int SPRITE_DIM = 32;
  localparam int DIM_W = $clog2(SPRITE_DIM);

  localparam logic [15:0] KEY_RGB565 = 16'hF81F;

  localparam logic [2:0] REG_XLO  = 3'd0;
  localparam logic [2:0] REG_XHI  = 3'd1;
  localparam logic [2:0] REG_YLO  = 3'd2;
  localparam logic [2:0] REG_YHI  = 3'd3;
  localparam logic [2:0] REG_CTRL = 3'd4;

  typedef struct packed {
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
  } rgb565_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        en;
  } sprite_pos_t;

  function automatic logic [23:0] rgb565_to_888(rgb565_t c);
    return {c.r5, c.r5[4:2],
            c.g6, c.g6[5:4],
            c.b5, c.b5[4:2]};
  endfunction

endpackage

// File: rtl/sprite_fetch_if.sv
// Avalon write-only register port of the sprite block.
// The bus side drives, the sprite block listens.
interface sprite_fetch_if;

  logic       chipselect;
  logic       write;
  logic [2:0] address;
  logic [7:0] writedata;

  modport master (
    output chipselect,
    output write,
    output address,
    output writedata
  );

  modport slave (
    input chipselect,
    input write,
    input address,
    input writedata
  );

endinterface

// File: rtl/sprite_regs.sv
// Avalon decode, staging and shadow position registers.
// Staged values reach the display only at the vblank commit point.
module sprite_regs
  import sprite_pkg::*;
#(
  parameter logic [9:0] VBLANK_LINE = 10'd480
) (
  input  logic          clk,
  input  logic          reset,
  sprite_fetch_if.slave bus,
  input  logic [10:0]   hcount,
  input  logic [9:0]    vcount,
  output sprite_pos_t   shadow,
  output logic          frame_commit
);

  sprite_pos_t staging;
  logic        pending;
  logic        wr;
  logic        req;
  logic        commit;

  assign wr = bus.chipselect && bus.write;

  assign req = wr
            && bus.address == REG_CTRL
            && bus.writedata[1];

  assign commit = pending
               && hcount == '0
               && vcount == VBLANK_LINE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      staging <= '0;
    end else if (wr) begin
      unique case (1'b1)
        bus.address == REG_XLO:
          staging.x[7:0] <= bus.writedata;
        bus.address == REG_XHI:
          staging.x[15:8] <= bus.writedata;
        bus.address == REG_YLO:
          staging.y[7:0] <= bus.writedata;
        bus.address == REG_YHI:
          staging.y[15:8] <= bus.writedata;
        bus.address == REG_CTRL:
          staging.en <= bus.writedata[0];
        default: ;
      endcase
    end
  end

  // a request landing on the commit clk survives for the next frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow       <= '0;
      pending      <= 1'b0;
      frame_commit <= 1'b0;
    end else begin
      frame_commit <= commit;
      pending      <= (pending && !commit) || req;
      if (commit) begin
        shadow <= staging;
      end
    end
  end

endmodule

// File: rtl/sprite_fetch.sv
// Sprite hit test, ROM address generation and colour pipeline.
// Output lags the hcount/vcount sample by three clks.
module sprite_fetch
  import sprite_pkg::*;
#(
  parameter logic [9:0] VBLANK_LINE = 10'd480
) (
  input  logic          clk,
  input  logic          reset,
  sprite_fetch_if.slave bus,
  input  logic [10:0]   hcount,
  input  logic [9:0]    vcount,
  output logic [9:0]    rom_addr,
  input  logic [15:0]   rom_data,
  output logic          pix_valid,
  output logic [23:0]   pix_rgb,
  output logic          frame_commit
);

  localparam logic [16:0] DIM17 = 17'(SPRITE_DIM);

  sprite_pos_t      shadow;
  logic [9:0]       col;
  logic [9:0]       row;
  logic [16:0]      col_w;
  logic [16:0]      row_w;
  logic [16:0]      x_w;
  logic [16:0]      y_w;
  logic             hit;
  logic             hit_d1;
  logic             hit_d2;
  logic             opaque;
  logic [DIM_W-1:0] dx;
  logic [DIM_W-1:0] dy;
  rgb565_t          texel;
  logic             unused_lsb;

  sprite_regs #(
    .VBLANK_LINE(VBLANK_LINE)
  ) u_regs (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .hcount       (hcount),
    .vcount       (vcount),
    .shadow       (shadow),
    .frame_commit (frame_commit)
  );

  assign col = hcount[10:1];
  assign row = vcount;
  assign unused_lsb = hcount[0];

  // 17-bit compare so x+DIM never wraps
  assign col_w = 17'(col);
  assign row_w = 17'(row);
  assign x_w   = 17'(shadow.x);
  assign y_w   = 17'(shadow.y);

  assign hit = shadow.en
            && col_w >= x_w
            && col_w < x_w + DIM17
            && row_w >= y_w
            && row_w < y_w + DIM17;

  assign dx = col[DIM_W-1:0] - shadow.x[DIM_W-1:0];
  assign dy = row[DIM_W-1:0] - shadow.y[DIM_W-1:0];

  assign texel  = rom_data;
  assign opaque = hit_d2 && rom_data != KEY_RGB565;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_d1    <= 1'b0;
      hit_d2    <= 1'b0;
      rom_addr  <= '0;
      pix_valid <= 1'b0;
      pix_rgb   <= '0;
    end else begin
      hit_d1    <= hit;
      hit_d2    <= hit_d1;
      rom_addr  <= hit ? {dy, dx} : '0;
      pix_valid <= opaque;
      pix_rgb   <= opaque ? rgb565_to_888(texel) : '0;
    end
  end

endmodule

// File: tb/tb_sprite_fetch.sv
// Randomized bench for sprite_fetch against a pixel-level model.
// A synchronous ROM model answers rom_addr one clk later.
module tb_sprite_fetch;
  import sprite_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic [9:0]  rom_addr;
  logic [15:0] rom_data = '0;
  logic        pix_valid;
  logic [23:0] pix_rgb;
  logic        frame_commit;

  sprite_fetch_if bus();

  sprite_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .hcount       (hcount),
    .vcount       (vcount),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .pix_valid    (pix_valid),
    .pix_rgb      (pix_rgb),
    .frame_commit (frame_commit)
  );

  always #5 clk = ~clk;

  logic [15:0] rom_mem [1024];

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  int n_cmp = 0;
  int n_err = 0;

  // model state: what software staged and what the display shows
  logic [15:0] st_x, st_y, sh_x, sh_y;
  bit          st_en, sh_en, pend;
  bit          m1_v, m2_v;
  logic [23:0] m1_rgb, m2_rgb;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] expand(input logic [15:0] w);
    int r, g, b;
    r = int'(w[15:11]);
    g = int'(w[10:5]);
    b = int'(w[4:0]);
    return 24'(((r * 8 + r / 4) << 16)
             + ((g * 4 + g / 16) << 8)
             + (b * 8 + b / 4));
  endfunction

  task automatic mreset();
    st_x = 0; st_y = 0; st_en = 0;
    sh_x = 0; sh_y = 0; sh_en = 0;
    pend = 0;
    m1_v = 0; m2_v = 0;
    m1_rgb = 0; m2_rgb = 0;
  endtask

  // one clk: predict, advance, compare
  task automatic tick();
    int col, row, x, y, a;
    bit hit, cm, cv, e_pv, wr;
    logic [23:0] crgb, e_rgb;
    if (reset) begin
      mreset();
      a = 0; cm = 0; e_pv = 0; e_rgb = 0;
    end else begin
      col = int'(hcount) / 2;
      row = int'(vcount);
      x = int'(sh_x);
      y = int'(sh_y);
      hit = sh_en && col >= x && col < x + SPRITE_DIM
                  && row >= y && row < y + SPRITE_DIM;
      a = hit ? (row - y) * SPRITE_DIM + (col - x) : 0;
      cv = hit && rom_mem[a] != 16'hF81F;
      crgb = cv ? expand(rom_mem[a]) : 24'd0;
      cm = pend && hcount == 0 && vcount == 10'd480;
      e_pv = m2_v; e_rgb = m2_rgb;
      m2_v = m1_v; m2_rgb = m1_rgb;
      m1_v = cv; m1_rgb = crgb;
      if (cm) begin
        sh_x = st_x; sh_y = st_y; sh_en = st_en;
      end
      wr = bus.chipselect && bus.write;
      pend = (pend && !cm)
          || (wr && bus.address == 3'd4 && bus.writedata[1]);
      if (wr) begin
        case (bus.address)
          3'd0: st_x[7:0] = bus.writedata;
          3'd1: st_x[15:8] = bus.writedata;
          3'd2: st_y[7:0] = bus.writedata;
          3'd3: st_y[15:8] = bus.writedata;
          3'd4: st_en = bus.writedata[0];
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
    chk("rom_addr", 32'(rom_addr), 32'(a));
    chk("frame_commit", 32'(frame_commit), 32'(cm));
    chk("pix_valid", 32'(pix_valid), 32'(e_pv));
    chk("pix_rgb", 32'(pix_rgb), 32'(e_rgb));
  endtask

  task automatic wreg(input logic [2:0] a, input logic [7:0] d);
    bus.chipselect = 1'b1;
    bus.write = 1'b1;
    bus.address = a;
    bus.writedata = d;
    tick();
    bus.chipselect = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic at(input int col, input int row, input int n);
    hcount = 11'(col * 2);
    vcount = 10'(row);
    repeat (n) tick();
  endtask

  task automatic stage(input logic [15:0] x,
                       input logic [15:0] y,
                       input logic [7:0] ctrl);
    wreg(3'd0, x[7:0]);
    wreg(3'd1, x[15:8]);
    wreg(3'd2, y[7:0]);
    wreg(3'd3, y[15:8]);
    wreg(3'd4, ctrl);
  endtask

  task automatic vblank();
    hcount = 11'd0;
    vcount = 10'd480;
    tick();
    hcount = 11'd2;
    vcount = 10'd0;
  endtask

  initial begin
    bus.chipselect = 1'b0;
    bus.write = 1'b0;
    bus.address = '0;
    bus.writedata = '0;
    mreset();
    for (int i = 0; i < 1024; i++) begin
      rom_mem[i] = ($urandom_range(0, 7) == 0) ? 16'hF81F
                                               : 16'($urandom);
    end
    rom_mem[0]    = 16'hF800;
    rom_mem[1]    = 16'h07E0;
    rom_mem[2]    = 16'hF81F;
    rom_mem[330]  = 16'h1234;
    rom_mem[1023] = 16'h001F;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_pix_rgb", 32'(pix_rgb), 32'd0);
    chk("rst_commit", 32'(frame_commit), 32'd0);
    #2 reset = 1'b0;

    // basic placement and colour
    stage(16'd320, 16'd160, 8'h03);
    at(320, 160, 4);
    chk("before_commit", 32'(pix_valid), 32'd0);
    vblank();
    chk("commit_pulse", 32'(frame_commit), 32'd1);
    tick();
    chk("commit_once", 32'(frame_commit), 32'd0);
    at(320, 160, 4);
    chk("origin_addr", 32'(rom_addr), 32'h000);
    chk("origin_rgb", 32'(pix_rgb), 32'hFF0000);
    at(321, 160, 4);
    chk("green_rgb", 32'(pix_rgb), 32'h00FF00);
    at(322, 160, 4);
    chk("key_valid", 32'(pix_valid), 32'd0);
    chk("key_rgb", 32'(pix_rgb), 32'd0);
    at(351, 191, 4);
    chk("corner_addr", 32'(rom_addr), 32'h3FF);
    chk("corner_rgb", 32'(pix_rgb), 32'h0000FF);
    at(319, 160, 4);
    chk("left_edge", 32'(pix_valid), 32'd0);
    at(352, 160, 4);
    chk("right_edge", 32'(pix_valid), 32'd0);
    at(320, 159, 4);
    chk("top_edge", 32'(pix_valid), 32'd0);
    at(320, 192, 4);
    chk("bottom_edge", 32'(pix_valid), 32'd0);

    // staging without a request never shows
    wreg(3'd0, 8'd100);
    wreg(3'd1, 8'd0);
    for (int i = 0; i < 200; i++) begin
      hcount = 11'($urandom_range(0, 1599));
      vcount = 10'($urandom_range(0, 524));
      tick();
    end
    vblank();
    chk("no_req_commit", 32'(frame_commit), 32'd0);
    at(320, 160, 4);
    chk("still_at_320", 32'(pix_valid), 32'd1);

    // request on the commit clk waits a frame
    hcount = 11'd0;
    vcount = 10'd480;
    wreg(3'd4, 8'h03);
    chk("simul_no_commit", 32'(frame_commit), 32'd0);
    at(100, 160, 4);
    chk("simul_not_moved", 32'(pix_valid), 32'd0);
    vblank();
    chk("simul_next_commit", 32'(frame_commit), 32'd1);
    at(100, 160, 4);
    chk("moved_to_100", 32'(pix_rgb), 32'hFF0000);

    // commit point uses the old staged enable
    stage(16'd320, 16'd160, 8'h03);
    hcount = 11'd0;
    vcount = 10'd480;
    wreg(3'd4, 8'h02);
    chk("old_pend_commit", 32'(frame_commit), 32'd1);
    at(320, 160, 4);
    chk("old_enable_used", 32'(pix_valid), 32'd1);
    vblank();
    chk("new_pend_commit", 32'(frame_commit), 32'd1);
    at(320, 160, 4);
    chk("disabled_next", 32'(pix_valid), 32'd0);

    // off-screen and huge positions never hit
    stage(16'h0400, 16'd0, 8'h03);
    vblank();
    at(1023, 5, 4);
    chk("x1024_edge", 32'(pix_valid), 32'd0);
    for (int i = 0; i < 300; i++) begin
      hcount = 11'($urandom);
      vcount = 10'($urandom_range(0, 40));
      tick();
    end
    stage(16'hFFF0, 16'd0, 8'h03);
    vblank();
    at(0, 5, 4);
    chk("no_wrap_col0", 32'(pix_valid), 32'd0);
    at(8, 5, 4);
    chk("no_wrap_col8", 32'(rom_addr), 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int r, c;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        wreg(3'($urandom_range(0, 7)), 8'($urandom));
      end else if (r < 7) begin
        vblank();
      end else if (r < 8) begin
        stage(($urandom_range(0, 9) == 0) ? 16'($urandom)
                                          : 16'($urandom_range(0, 700)),
              ($urandom_range(0, 9) == 0) ? 16'($urandom)
                                          : 16'($urandom_range(0, 500)),
              8'($urandom_range(1, 3)));
      end else begin
        if (r < 70) begin
          c = int'(sh_x) + $urandom_range(0, 40) - 4;
          hcount = 11'(c * 2 + $urandom_range(0, 1));
          vcount = 10'(int'(sh_y) + $urandom_range(0, 40) - 4);
        end else begin
          hcount = 11'($urandom);
          vcount = 10'($urandom_range(0, 524));
        end
        repeat ($urandom_range(1, 2)) tick();
      end
    end

    // asynchronous reset while the sprite is showing
    stage(16'd320, 16'd160, 8'h03);
    vblank();
    at(330, 170, 4);
    chk("pre_reset_valid", 32'(pix_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rom_addr", 32'(rom_addr), 32'd0);
    chk("async_pix_valid", 32'(pix_valid), 32'd0);
    chk("async_pix_rgb", 32'(pix_rgb), 32'd0);
    chk("async_commit", 32'(frame_commit), 32'd0);
    mreset();
    tick();
    tick();
    #2 reset = 1'b0;
    at(330, 170, 5);
    chk("post_reset_blank", 32'(pix_valid), 32'd0);
    vblank();
    chk("post_reset_no_commit", 32'(frame_commit), 32'd0);
    at(330, 170, 5);
    chk("still_blank", 32'(pix_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_fetch.md
# sprite_fetch

Generates the address stream for the 32x32 apple sprite ROM and returns a per-pixel sprite colour and valid flag to the VGA output stage. Software moves the sprite through byte-wide Avalon registers. A requested position is committed only at the start of vertical blanking, so the sprite never tears mid-frame. Sits between the Avalon bus, the vga_counters hcount/vcount outputs, the sprite ROM, and the colour mux in the VGA display block.

## Interface
- SPRITE_DIM, 32: sprite width and height in pixels; must be a power of two.
- KEY_RGB565, 16'hF81F: ROM colour that is treated as transparent.
- VBLANK_LINE, 480: vcount value at which pending registers commit.

- clk  in  1  50 MHz system clock.
- reset  in  1  reset, asynchronous, active-high.
- chipselect  in  1  Avalon select.
- write  in  1  Avalon write strobe.
- address  in  3  register index.
- writedata  in  8  register write data.
- hcount  in  11  from vga_counters; hcount[10:1] is the pixel column.
- vcount  in  10  from vga_counters; pixel row.
- rom_addr  out  10  sprite ROM word address, {row[4:0], col[4:0]}.
- rom_data  in  16  RGB565 ROM output, valid one clk after rom_addr.
- pix_valid  out  1  sprite covers this pixel and it is opaque.
- pix_rgb  out  24  RGB888 sprite colour.
- frame_commit  out  1  one-clk pulse when the shadow registers update.

## Operation
- Register map (write-only; writes only when chipselect && write):
  - 0: x[7:0]
  - 1: x[15:8]
  - 2: y[7:0]
  - 3: y[15:8]
  - 4: control. Bit0 = enable; bit1 = commit request (self-clearing).
  - 5–7 are ignored.
- Registers 0–4 write staging registers. Writing control with bit1=1 sets `pending`.
- Commit point:
  - Condition: hcount==0 && vcount==VBLANK_LINE && pending.
  - Copies staging x, y and enable into the shadow registers.
  - Clears pending and pulses frame_commit.
- Simultaneous commit request and commit point:
  - The commit point uses the old pending value and the old staging contents.
  - The new request stays pending for the next frame.
- Staging writes without a commit request never affect the display.
- Hit test uses shadow values, col = hcount[10:1], row = vcount:
  - Compare in 17-bit unsigned arithmetic, so there is no wrap.
  - hit = col >= x && col < x+SPRITE_DIM && row >= y && row < y+SPRITE_DIM && enable.
  - A sprite with x or y above 1023 is never hit.
- ROM address: dx = col−x and dy = row−y, low 5 bits each. On a miss, rom_addr holds 0.
- Colour expansion is bit replication:
  - R = {r5, r5[4:2]}
  - G = {g6, g6[5:4]}
  - B = {b5, b5[4:2]}
- Transparency: pix_valid = hit_d2 && rom_data != KEY_RGB565. When pix_valid=0, pix_rgb = 0.

## Timing
- Three-stage pipeline, all registered:
  - Cycle n: hcount/vcount sampled.
  - Cycle n+1: rom_addr and hit_d1 valid.
  - Cycle n+2: rom_data valid; hit_d2 valid.
  - Cycle n+3: pix_valid and pix_rgb valid.
- The downstream mux delays its own hcount/vcount/VGA_BLANK_n qualification by 3 clks.
- Each pixel lasts 2 clks, so the output is stable for both clks of a pixel.
- frame_commit is registered. It is high in the clk after the commit-point sample.
- Reset (asynchronous):
  - Staging and shadow x=0, y=0, enable=0; pending=0.
  - Pipeline hit flags = 0.
  - rom_addr=0, pix_valid=0, pix_rgb=0, frame_commit=0.
- Reset mid-frame blanks the sprite immediately, because shadow enable=0.
- No output depends combinationally on any input.

## Structure
- Shared package sprite_pkg holds:
  - register index constants REG_XLO..REG_CTRL;
  - SPRITE_DIM;
  - KEY_RGB565;
  - typedef rgb565_t, a packed struct of r5, g6, b5;
  - function rgb565_to_888.
- One sub-module, sprite_regs: Avalon decode, staging, pending, shadow and commit logic.
- The hit test and pipeline stay in the top-level sprite_fetch.
- The ROM instance lives outside this block.

## Test plan
- Stage x=320, y=160, enable=1, commit; run to vcount 480 → frame_commit pulses once. In the next frame, rom_addr=0 at col 320/row 160, 3 clks after the sample, and rom_addr=10'h3FF at col 351/row 191.
- Boundaries with x=320, y=160: col 319 and col 352 → pix_valid=0. Row 159 and row 192 → pix_valid=0.
- Transparency: ROM returns 16'hF81F → pix_valid=0, pix_rgb=0. ROM returns 16'hF800 → pix_rgb=24'hFF0000. ROM returns 16'h07E0 → pix_rgb=24'h00FF00.
- Staging write x=100 with no commit → display stays at x=320 indefinitely. A commit request issued on exactly the commit-point clk → applied one frame later, not in this frame.
- x=16'h0400 committed → no pix_valid anywhere in the frame. x=16'hFFF0 → no hit at col 0, so no wrap-around.
- Assert reset mid-line while pix_valid=1 → all outputs 0 asynchronously. After release, no sprite appears until a new commit.
